sr_reg_bank: RTL and testbench
==============================

// Module: sr_reg_bank
// PURPOSE
//  Parametrised bank of WIDTH independent SR storage bits with one shared clock, enable and sync clear.
//  Conflict policy (S=R=1) is selected per instance by MODE; no X is ever produced.
//  Conflicts are logged per bit (sticky) and counted (saturating) for status/debug readout.
//  Used wherever many set/clear event flags are needed (interrupt pending, status latches).
// PARAMETERS
//  WIDTH      8     number of SR bits in the bank (>=1)
//  MODE       0     S=R=1 policy: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle (JK)
//  RESET_VAL  0     WIDTH-bit value loaded into q by rst and by sync_clr
//  CNT_W      8     width of conflict_cnt (>=1)
// PORTS
//  clk              in   1      clock, all state on rising edge
//  rst              in   1      asynchronous reset, active-high
//  en               in   1      update enable; 0 = all bits hold, s/r ignored
//  sync_clr         in   1      synchronous clear of q to RESET_VAL; priority over en
//  s                in   WIDTH  per-bit set request
//  r                in   WIDTH  per-bit reset request
//  conflict_ack     in   1      clears conflict_sticky and conflict_cnt
//  q                out  WIDTH  stored bits (registered)
//  conflict_sticky  out  WIDTH  per-bit sticky flag: bit saw S=R=1 while enabled
//  conflict_cnt     out  CNT_W  count of cycles with >=1 conflicting bit, saturating
//  q_rise           out  WIDTH  (SR_BANK_EDGE_DETECT_EN only) 1-cycle pulse, bit went 0->1
//  q_fall           out  WIDTH  (SR_BANK_EDGE_DETECT_EN only) 1-cycle pulse, bit went 1->0
// BEHAVIOUR
//  - rst=1 (async, any time incl. mid-operation): q=RESET_VAL, conflict_sticky=0, conflict_cnt=0,
//    q_rise=q_fall=0; held while rst=1; normal operation from first rising edge after release.
//  - Latency: all outputs registered; q reflects s/r/en/sync_clr one edge after sampling.
//  - Priority per edge: rst > sync_clr > en. sync_clr=1 -> q<=RESET_VAL regardless of en/s/r;
//    conflict logic not updated that cycle (no sticky set, no count).
//  - en=0, sync_clr=0: q holds; no conflict recorded even if s&r!=0.
//  - en=1, per bit i: {s,r}=00 hold; 01 -> 0; 10 -> 1; 11 -> MODE policy:
//    MODE0 hold, MODE1 -> 1, MODE2 -> 0, MODE3 -> ~q[i]. MODE outside 0..3 is illegal (elab check).
//  - Conflict vector c = (en & ~sync_clr) ? (s & r) : 0.
//  - conflict_sticky: next = (conflict_ack ? 0 : conflict_sticky) | c  (new conflict wins over ack).
//  - conflict_cnt: base = conflict_ack ? 0 : conflict_cnt; next = base + (|c), saturating at
//    2^CNT_W-1 (holds at max, never wraps). One increment per cycle regardless of bits in conflict.
//  - Ack + conflict same edge: sticky = c, cnt = 1.
//  - Bits are fully independent; no cross-bit interaction except shared en/sync_clr/counter.
// CONFIGURATION
//  - Macro SR_BANK_EDGE_DETECT_EN defined: q_rise/q_fall ports exist; registered alongside q:
//    q_rise <= q_next & ~q, q_fall <= ~q_next & q, so a pulse is high in exactly the cycle q first
//    shows the new value. Changes caused by sync_clr pulse normally; rst gives no pulses.
//  - Macro undefined: q_rise/q_fall ports and logic absent; all other behaviour identical.
// TESTING  (WIDTH=4, RESET_VAL=4'b0000, CNT_W=2 unless stated)
//  - Reset: drive s=4'hF mid-run, assert rst between edges -> q=0, sticky=0, cnt=0 immediately,
//    before next edge; held until release.
//  - Basic: en=1 s=4'b0101 r=0 -> q=4'b0101 next edge; then s=0 r=4'b0001 -> q=4'b0100;
//    en=0 s=4'hF -> q stays 4'b0100.
//  - MODE sweep, q=4'b0011, s=r=4'b0110, en=1: MODE0->0011, MODE1->0111, MODE2->0001, MODE3->0101;
//    sticky=4'b0110, cnt=1 in each.
//  - Counter: 5 consecutive conflict cycles -> cnt 1,2,3,3,3 (saturates); conflict_ack with no
//    conflict -> sticky=0 cnt=0; ack with s=r=4'b1000 -> sticky=4'b1000 cnt=1.
//  - sync_clr: RESET_VAL=4'b1010, q=4'b0101, sync_clr=1 en=1 s=r=4'hF -> q=4'b1010, sticky/cnt
//    unchanged; with SR_BANK_EDGE_DETECT_EN same cycle q_rise=4'b1010, q_fall=4'b0101.
//  - Edge detect off: compile without macro, rerun basic test -> identical q/sticky/cnt trace.

Source files
------------

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: bank of WIDTH independent SR storage bits sharing clock, enable and sync clear.
// The S=R=1 conflict policy is fixed per instance by MODE (0 hold, 1 set, 2 reset, 3 toggle).
// Conflicts are recorded per bit (sticky) and counted per cycle (saturating).
// Optional feature: define SR_BANK_EDGE_DETECT_EN to add registered q_rise/q_fall pulse outputs.
module sr_reg_bank #(
    parameter int unsigned         WIDTH     = 8,
    parameter int unsigned         MODE      = 0,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0,
    parameter int unsigned         CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             conflict_ack,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] conflict_sticky,
`ifdef SR_BANK_EDGE_DETECT_EN
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall
`else
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reject illegal configurations at elaboration time.
    if (MODE > 3) begin : g_bad_mode
        $error("sr_reg_bank: MODE must be 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sr_reg_bank: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("sr_reg_bank: CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] conflict;
    logic [WIDTH-1:0] sticky_next;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;

    // Next value of q: sync_clr beats en, then per-bit SR decode with the MODE conflict policy.
    always_comb begin
        q_next = q;
        if (sync_clr) begin
            q_next = RESET_VAL;
        end else if (en) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({s[i], r[i]})
                    2'b01:   q_next[i] = 1'b0;
                    2'b10:   q_next[i] = 1'b1;
                    2'b11: begin
                        case (MODE)
                            1:       q_next[i] = 1'b1;
                            2:       q_next[i] = 1'b0;
                            3:       q_next[i] = ~q[i];
                            default: q_next[i] = q[i];
                        endcase
                    end
                    default: q_next[i] = q[i];
                endcase
            end
        end
    end

    // Conflict bookkeeping: a fresh conflict always wins over a same-cycle ack.
    always_comb begin
        conflict    = (en && !sync_clr) ? (s & r) : '0;
        sticky_next = (conflict_ack ? '0 : conflict_sticky) | conflict;
        cnt_base    = conflict_ack ? '0 : conflict_cnt;
        cnt_next    = cnt_base;
        // One increment per cycle no matter how many bits conflict; hold at max.
        if ((|conflict) && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    // Stored bits and conflict status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q               <= RESET_VAL;
            conflict_sticky <= '0;
            conflict_cnt    <= '0;
        end else begin
            q               <= q_next;
            conflict_sticky <= sticky_next;
            conflict_cnt    <= cnt_next;
        end
    end

`ifdef SR_BANK_EDGE_DETECT_EN
    // Edge pulses registered with q so each is high exactly when q first shows the new value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_rise <= '0;
            q_fall <= '0;
        end else begin
            q_rise <= q_next & ~q;
            q_fall <= ~q_next & q;
        end
    end
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank: five 4-bit banks (MODE 0..3 with RESET_VAL 0, plus MODE 0 with RESET_VAL 1010)
// driven in parallel; a reference model pushes expected state per cycle into a scoreboard queue.
module tb_sr_reg_bank;

    localparam int NI = 5;

    typedef struct packed {
        logic [NI-1:0][3:0] q;
        logic [NI-1:0][3:0] st;
        logic [NI-1:0][1:0] cnt;
        logic [NI-1:0][3:0] rise;
        logic [NI-1:0][3:0] fall;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sync_clr;
    logic [3:0] s;
    logic [3:0] r;
    logic       conflict_ack;

    logic [NI-1:0][3:0] dq;
    logic [NI-1:0][3:0] dst;
    logic [NI-1:0][1:0] dcnt;
    logic [NI-1:0][3:0] drise;
    logic [NI-1:0][3:0] dfall;

    // reference model state
    logic [NI-1:0][3:0] m_q;
    logic [NI-1:0][3:0] m_st;
    logic [NI-1:0][1:0] m_cnt;
    logic [NI-1:0][3:0] m_rise;
    logic [NI-1:0][3:0] m_fall;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sr_reg_bank #(
            .WIDTH     (4),
            .MODE      ((k < 4) ? k : 0),
            .RESET_VAL ((k == 4) ? 4'b1010 : 4'b0000),
            .CNT_W     (2)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .en              (en),
            .sync_clr        (sync_clr),
            .s               (s),
            .r               (r),
            .conflict_ack    (conflict_ack),
            .q               (dq[k]),
            .conflict_sticky (dst[k]),
`ifdef SR_BANK_EDGE_DETECT_EN
            .conflict_cnt    (dcnt[k]),
            .q_rise          (drise[k]),
            .q_fall          (dfall[k])
`else
            .conflict_cnt    (dcnt[k])
`endif
        );
    end

`ifndef SR_BANK_EDGE_DETECT_EN
    assign drise = '0;
    assign dfall = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] reset_val(input int k);
        return (k == 4) ? 4'b1010 : 4'b0000;
    endfunction

    function automatic int mode_of(input int k);
        return (k < 4) ? k : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_q[k]    = reset_val(k);
            m_st[k]   = '0;
            m_cnt[k]  = '0;
            m_rise[k] = '0;
            m_fall[k] = '0;
        end
    endtask

    // advance the model one edge using the currently driven inputs
    task automatic model_step();
        logic [3:0] nq;
        logic [3:0] c;
        int         base;
        c = (en && !sync_clr) ? (s & r) : 4'b0000;
        for (int k = 0; k < NI; k++) begin
            nq = m_q[k];
            if (sync_clr) begin
                nq = reset_val(k);
            end else if (en) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i] && !r[i])      nq[i] = 1'b1;
                    else if (!s[i] && r[i]) nq[i] = 1'b0;
                    else if (s[i] && r[i]) begin
                        if (mode_of(k) == 1)      nq[i] = 1'b1;
                        else if (mode_of(k) == 2) nq[i] = 1'b0;
                        else if (mode_of(k) == 3) nq[i] = !m_q[k][i];
                    end
                end
            end
            m_rise[k] = nq & ~m_q[k];
            m_fall[k] = ~nq & m_q[k];
            m_q[k]    = nq;
            m_st[k]   = (conflict_ack ? 4'b0000 : m_st[k]) | c;
            base      = conflict_ack ? 0 : int'(m_cnt[k]);
            if (c != 4'b0000 && base < 3) base++;
            m_cnt[k]  = 2'(base);
        end
    endtask

    task automatic check_now(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.q%0d", tag, k), 32'(dq[k]), 32'(m_q[k]));
            check($sformatf("%s.sticky%0d", tag, k), 32'(dst[k]), 32'(m_st[k]));
            check($sformatf("%s.cnt%0d", tag, k), 32'(dcnt[k]), 32'(m_cnt[k]));
`ifdef SR_BANK_EDGE_DETECT_EN
            check($sformatf("%s.rise%0d", tag, k), 32'(drise[k]), 32'(m_rise[k]));
            check($sformatf("%s.fall%0d", tag, k), 32'(dfall[k]), 32'(m_fall[k]));
`endif
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.q%0d", tag, k), 32'(dq[k]), 32'(e.q[k]));
            check($sformatf("%s.sticky%0d", tag, k), 32'(dst[k]), 32'(e.st[k]));
            check($sformatf("%s.cnt%0d", tag, k), 32'(dcnt[k]), 32'(e.cnt[k]));
`ifdef SR_BANK_EDGE_DETECT_EN
            check($sformatf("%s.rise%0d", tag, k), 32'(drise[k]), 32'(e.rise[k]));
            check($sformatf("%s.fall%0d", tag, k), 32'(dfall[k]), 32'(e.fall[k]));
`endif
        end
    endtask

    // drive one cycle of stimulus, queue the expected result, compare after the edge
    task automatic step(input string tag, input logic e, input logic sc, input logic ack,
                        input logic [3:0] sv, input logic [3:0] rv);
        exp_t x;
        en           = e;
        sync_clr     = sc;
        conflict_ack = ack;
        s            = sv;
        r            = rv;
        model_step();
        x.q    = m_q;
        x.st   = m_st;
        x.cnt  = m_cnt;
        x.rise = m_rise;
        x.fall = m_fall;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        sync_clr     = 1'b0;
        conflict_ack = 1'b0;
        s            = '0;
        r            = '0;
        model_reset();
        #1;
        check_now("reset");
        @(negedge clk);
        rst = 1'b0;

        // basic set / reset / enable-hold
        step("basic_set", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b0000);
        check("basic_set_q", 32'(dq[0]), 32'h5);
        step("basic_clr", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001);
        check("basic_clr_q", 32'(dq[0]), 32'h4);
        step("basic_hold", 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000);
        check("basic_hold_q", 32'(dq[0]), 32'h4);

        // MODE sweep from q=0011 with s=r=0110
        step("sweep_pre", 1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100);
        step("sweep", 1'b1, 1'b0, 1'b0, 4'b0110, 4'b0110);
        check("sweep_m0", 32'(dq[0]), 32'b0011);
        check("sweep_m1", 32'(dq[1]), 32'b0111);
        check("sweep_m2", 32'(dq[2]), 32'b0001);
        check("sweep_m3", 32'(dq[3]), 32'b0101);
        check("sweep_sticky", 32'(dst[3]), 32'b0110);
        check("sweep_cnt", 32'(dcnt[3]), 32'd1);

        // ack without conflict clears status
        step("ack_clr", 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
        check("ack_clr_sticky", 32'(dst[0]), 32'd0);
        check("ack_clr_cnt", 32'(dcnt[0]), 32'd0);

        // five conflict cycles: counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            step($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
            check($sformatf("sat%0d_cnt", i), 32'(dcnt[0]), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // ack and conflict on the same edge: new conflict wins
        step("ack_conf", 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000);
        check("ack_conf_sticky", 32'(dst[0]), 32'b1000);
        check("ack_conf_cnt", 32'(dcnt[0]), 32'd1);

        // conflict while disabled is not recorded
        step("dis_conf", 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0111);

        // sync_clr beats en/s/r and leaves conflict state alone
        step("sc_pre", 1'b1, 1'b0, 1'b0, 4'b0101, 4'b1010);
        step("sync_clr", 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);
        check("sync_clr_q", 32'(dq[4]), 32'b1010);
        check("sync_clr_sticky", 32'(dst[4]), 32'b1000);
        check("sync_clr_cnt", 32'(dcnt[4]), 32'd1);
`ifdef SR_BANK_EDGE_DETECT_EN
        check("sync_clr_rise", 32'(drise[4]), 32'b1010);
        check("sync_clr_fall", 32'(dfall[4]), 32'b0101);
`endif

        // random traffic
        for (int i = 0; i < 40; i++) begin
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
                 4'($urandom), 4'($urandom));
        end

        // asynchronous reset between edges while s=F is being driven
        en       = 1'b1;
        sync_clr = 1'b0;
        s        = 4'b1111;
        r        = 4'b0000;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_now("async_rst");
        @(posedge clk);
        #1;
        check_now("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000);
        check("post_rst_q", 32'(dq[0]), 32'b0011);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
